// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// master drives operands and out_ready; slave is the controller.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one shared full-adder cell walks the operands LSB first,
// one bit per clock, with valid/ready handshakes on both sides.

module full_adder_1_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus_io
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             fa_s;
  logic             fa_c;

  full_adder_1_bit u_fa (
    .a_i (op_a_q[0]),
    .b_i (op_b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.in_valid) begin
            // Subtraction is a + ~b + 1, so sub overrides the caller's carry in.
            op_a_q     <= bus_io.a;
            op_b_q     <= bus_io.sub ? ~bus_io.b : bus_io.b;
            carry_q    <= bus_io.sub | bus_io.cin;
            cnt_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
          op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          carry_q <= fa_c;
          if (cnt_q == LastBit) begin
            // carry_q here is the carry into the MSB.
            ovf_q       <= carry_q ^ fa_c;
            cout_q      <= fa_c;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (bus_io.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus backpressure, reset-abort
// and back-to-back sequences.
module tb_serial_adder_ctrl;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid is seen; a stuck DUT returns the bound.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 30);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    check({tag, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    bus.sub      = v.sub;
    bus.in_valid = 1'b1;
    tick();
    // Scramble the inputs: the latched copy must be used from here on.
    bus.in_valid = 1'b0;
    bus.a        = ~v.a;
    bus.b        = 8'h5A;
    bus.cin      = ~v.cin;
    bus.sub      = ~v.sub;
    check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_sum"}, 32'(bus.sum), 32'(v.sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(v.cout));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(v.ovf));
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_idle"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum_held"}, 32'(bus.sum), 32'(v.sum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   acc[3];
    vec_t v;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[6] = '{a: 8'h05, b: 8'h05, cin: 1'b1, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h33, b: 8'h44, cin: 1'b1, sub: 1'b0, sum: 8'h78, cout: 1'b0, ovf: 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values.
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure, with in_valid held high through RUN and DONE.
    bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.a = 8'h11; bus.b = 8'h22;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_out_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_sum_%0d", i), 32'(bus.sum), 32'h96);
      check($sformatf("bp_cout_%0d", i), 32'(bus.cout), 32'd0);
      check($sformatf("bp_ovf_%0d", i), 32'(bus.overflow), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    check("bp_out_valid_back", 32'(bus.out_valid), 32'd0);
    wait_valid(lat);
    bus.in_valid = 1'b0;
    check("bp_second_latency", 32'(lat), 32'd9);
    check("bp_second_sum", 32'(bus.sum), 32'h33);
    check("bp_second_cout", 32'(bus.cout), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Asynchronous reset at bit 4 of a RUN.
    bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_sum", 32'(bus.sum), 32'd0);
    check("arst_cout", 32'(bus.cout), 32'd0);
    check("arst_ovf", 32'(bus.overflow), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    v = '{a: 8'h01, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0};
    run_vec(v, "post_rst");

    // Back-to-back with in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    bus.a = vecs[0].a; bus.b = vecs[0].b; bus.cin = vecs[0].cin; bus.sub = vecs[0].sub;
    bus.in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      lat = 0;
      while (!bus.in_ready && lat < 30) begin
        tick();
        lat++;
      end
      check($sformatf("b2b_ready_%0d", j), 32'(bus.in_ready), 32'd1);
      tick();
      acc[j] = cyc;
      if (j < 2) begin
        bus.a = vecs[j+1].a; bus.b = vecs[j+1].b;
        bus.cin = vecs[j+1].cin; bus.sub = vecs[j+1].sub;
      end else begin
        bus.in_valid = 1'b0;
      end
      wait_valid(lat);
      check($sformatf("b2b_latency_%0d", j), 32'(lat), 32'd8);
      check($sformatf("b2b_sum_%0d", j), 32'(bus.sum), 32'(vecs[j].sum));
      check($sformatf("b2b_cout_%0d", j), 32'(bus.cout), 32'(vecs[j].cout));
      check($sformatf("b2b_ovf_%0d", j), 32'(bus.overflow), 32'(vecs[j].ovf));
    end
    check("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'd10);
    check("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'd10);
    tick();
    bus.out_ready = 1'b0;
    check("b2b_final_idle", 32'(bus.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder/subtractor controller that sequences the team's existing 1-bit full adder cell, `full_adder_1_bit`, over WIDTH clock cycles.
- It accepts an operand pair through a valid/ready handshake and feeds one bit per cycle, LSB first, through a single instantiated `full_adder_1_bit`.
- It accumulates the sum in a shift register and presents the result through an output valid/ready handshake.
- It is the area-minimal arithmetic unit for slow datapaths that share one adder cell instead of a ripple array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operand pair (a, b, cin, sub) is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  1 = compute a - b (b inverted, carry in forced to 1).
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result bits.
- cout  output  1  final carry out; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, overflow=0. Operand, carry and counter registers are all 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. The result is discarded and all outputs take their reset values immediately (asynchronous).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid=1: latch a into op_a, and b (or ~b if sub=1) into op_b.
  - Load the carry register with cin (or 1 if sub=1), clear the bit counter, go to RUN.
  - sum, cout and overflow keep the previous result until the next accept.
- RUN:
  - Adder inputs are op_a[0], op_b[0] and the carry register.
  - Each edge: shift op_a and op_b right by 1; shift the adder's S in at sum[WIDTH-1] (sum shifts right); carry register <= adder's cout; counter +1.
  - On the edge where counter==WIDTH-1 (last bit): latch the previous carry register value XOR the new carry into overflow, set cout to the new carry, go to DONE.
  - in_valid is ignored and in_ready=0.
- DONE:
  - out_valid=1. sum, cout and overflow are stable while out_valid=1 && out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid falls and in_ready rises on the same edge.
  - No accept happens in the DONE cycle itself.
- Latency: operands accepted on edge k; out_valid is high from edge k+WIDTH onward.
- Throughput: at most one operation per WIDTH+2 cycles with out_ready held high.
- Arithmetic: the result is modulo 2^WIDTH. No saturation. Carry and borrow are reported only through cout.
- The counter reaches at most WIDTH-1. The last-bit compare is exact, with no wrap.
- Inputs a, b, cin and sub may change freely after the accept edge without affecting the result.

Test Plan:
- WIDTH=8, add: a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0, overflow=1. out_valid rises exactly 8 cycles after the accept edge.
- Add with carry wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Separately, a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Subtract:
  - a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow), overflow=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/overflow stay constant and in_ready stays 0. in_valid pulses during RUN/DONE are ignored and a second operand pair is not taken until after the return to IDLE.
- Reset mid-operation: assert rst_n=0 at bit 4 of a RUN -> all outputs return to reset values immediately. Release reset, issue 0x01+0x01 -> sum=0x02 with a clean 8-cycle latency.
- Back-to-back: in_valid and out_ready held high, 3 operations -> accept edges are exactly 10 cycles apart (WIDTH+2). All results are correct.
